// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; SDRAM timing primitive.
// Define SAT_COUNTER_CHECKS_EN to compile in simulation-only checks.
module sat_counter #(
  parameter int          count_width = 8,
  parameter int unsigned count_max   = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [count_width-1:0] count,
  output logic                   at_max
);

  localparam logic [count_width-1:0] M =
    count_width'(count_max);

  // Power-up value comes from register initialisation.
  logic [count_width-1:0] count_q = '0;
  logic [count_width-1:0] count_d;

  // Next state: clear wins, then increment until M, then hold.
  always_comb begin
    count_d = count_q;
    if (reset) begin
      count_d = '0;
    end else if (count_q != M) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count  = count_q;
  assign at_max = (count_q == M);

`ifdef SAT_COUNTER_CHECKS_EN
  if (count_width < 1) begin : g_chk_w
    $error("sat_counter: count_width must be >= 1");
  end

  if (count_width < 64) begin : g_chk_max
    if (64'(count_max) > ((64'd1 << count_width) - 64'd1)) begin : g_err
      $error("sat_counter: count_max truncated");
    end
  end

  // Count never exceeds the saturation value.
  a_le_max : assert property (
    @(posedge clk) count_q <= M
  ) else $error("sat_counter: count above max");

  // Only +1, hold at M, or clear are legal transitions.
  a_step : assert property (
    @(posedge clk) ##1
      (count_q == '0) ||
      (count_q == $past(count_q) + 1'b1) ||
      (count_q == M && $past(count_q) == M)
  ) else $error("sat_counter: illegal count step");
`endif

endmodule

// File: tb/tb_sat_counter.sv
// Bench for sat_counter: three instances (4/9, 3/7, 4/0),
// table-driven vectors plus hand sequences, queue scoreboard.
module tb_sat_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic       rst_c = 1'b0;
  logic [3:0] cnt_a;
  logic       max_a;
  logic [2:0] cnt_b;
  logic       max_b;
  logic [3:0] cnt_c;
  logic       max_c;

  sat_counter #(.count_width(4), .count_max(9)) u_a (
    .clk(clk), .reset(rst_a), .count(cnt_a), .at_max(max_a)
  );
  sat_counter #(.count_width(3), .count_max(7)) u_b (
    .clk(clk), .reset(rst_b), .count(cnt_b), .at_max(max_b)
  );
  sat_counter #(.count_width(4), .count_max(0)) u_c (
    .clk(clk), .reset(rst_c), .count(cnt_c), .at_max(max_c)
  );

  typedef struct {
    int ca; bit ma;
    int cb; bit mb;
    int cc; bit mc;
  } exp_t;

  typedef struct {
    bit rst;
    int exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   mdl_b = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: empty queue at %0t", $time);
      return;
    end
    e = sb.pop_front();
    chk("a.count",  32'(cnt_a), 32'(e.ca));
    chk("a.at_max", 32'(max_a), 32'(e.ma));
    chk("b.count",  32'(cnt_b), 32'(e.cb));
    chk("b.at_max", 32'(max_b), 32'(e.mb));
    chk("c.count",  32'(cnt_c), 32'(e.cc));
    chk("c.at_max", 32'(max_c), 32'(e.mc));
  endtask

  // Drive one cycle (called at a negedge), push expectation,
  // then compare on the next negedge after the rising edge.
  task automatic cycle(input bit ra, input bit rb,
                       input bit rc, input int ca);
    exp_t e;
    rst_a = ra;
    rst_b = rb;
    rst_c = rc;
    mdl_b = rb ? 0 : (mdl_b < 7 ? mdl_b + 1 : 7);
    e.ca = ca;
    e.ma = (ca == 9);
    e.cb = mdl_b;
    e.mb = (mdl_b == 7);
    e.cc = 0;
    e.mc = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    compare();
  endtask

  initial begin : main
    exp_t e0;

    // Counting from power-up, then at least 10 cycles at 9.
    for (int k = 1; k <= 9; k++) tbl.push_back('{1'b0, k});
    for (int k = 0; k < 10; k++) tbl.push_back('{1'b0, 9});
    // Clear while saturated, re-saturate 9 edges later.
    tbl.push_back('{1'b1, 0});
    for (int k = 1; k <= 9; k++) tbl.push_back('{1'b0, k});
    tbl.push_back('{1'b0, 9});
    // One-cycle pulse while count is 5.
    tbl.push_back('{1'b1, 0});
    for (int k = 1; k <= 5; k++) tbl.push_back('{1'b0, k});
    tbl.push_back('{1'b1, 0});
    for (int k = 1; k <= 3; k++) tbl.push_back('{1'b0, k});

    // Power-up state before any edge.
    e0 = '{0, 1'b0, 0, 1'b0, 0, 1'b1};
    sb.push_back(e0);
    #1;
    compare();

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, 1'b0,
            1'($urandom_range(0, 1)), tbl[i].exp);
    end

    // Clear held for 20 cycles, then 0 -> 1 -> 2.
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 1'b0, 1);
    cycle(1'b0, 1'b0, 1'b0, 2);

    // Clear the 3-bit counter; it re-saturates at 7 and holds.
    cycle(1'b0, 1'b1, 1'b0, 3);
    for (int k = 4; k <= 13; k++) begin
      cycle(1'b0, 1'b0, 1'b0, (k > 9) ? 9 : k);
    end

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: %0d left over", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
